// File: rtl/cond_flag_unit.sv
// cond_flag_unit: architectural NZCV register, ARM condition check,
// registered execute/skip decision and saturating skip counter.
module cond_flag_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         C_IS_BORROW = 1'b1,
  parameter int         CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [3:0]       i_cond,
  input  logic             i_flag_we,
  input  logic [3:0]       i_flag,
  input  logic             i_stall,
  input  logic             i_cnt_clr,
  output logic             o_valid,
  output logic             o_exec,
  output logic [3:0]       o_flags,
  output logic [CNT_W-1:0] o_skip_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic             exec_q, exec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic n, z, c, v;
  logic base_ok;
  logic pass;
  logic accept;
  logic flag_wr;

  assign {n, z, c, v} = flags_q;
  assign accept  = i_valid & ~i_stall;
  assign flag_wr = accept & i_flag_we & pass;

  // Odd codes invert the even base test; AL/NV pair follows the same rule.
  always_comb begin
    base_ok = 1'b1;
    case (i_cond[3:1])
      3'd0:    base_ok = z;
      3'd1:    base_ok = c;
      3'd2:    base_ok = n;
      3'd3:    base_ok = v;
      3'd4:    base_ok = c & ~z;
      3'd5:    base_ok = (n == v);
      3'd6:    base_ok = ~z & (n == v);
      default: base_ok = 1'b1;
    endcase
    pass = base_ok ^ i_cond[0];
  end

  // Flags only change for an accepted, passing flag-setting instruction.
  always_comb begin
    flags_d = flags_q;
    if (flag_wr) begin
      flags_d = {i_flag[3], i_flag[2],
                 i_flag[1] ^ C_IS_BORROW, i_flag[0]};
    end
  end

  // Decision stage: follows the input when not stalled, holds otherwise.
  always_comb begin
    valid_d = valid_q;
    exec_d  = exec_q;
    if (!i_stall) begin
      valid_d = i_valid;
      exec_d  = i_valid & pass;
    end
  end

  // Clear wins over increment and is honoured even while stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (accept && !pass && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with immediate reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      flags_q <= RESET_FLAGS;
      valid_q <= 1'b0;
      exec_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      valid_q <= valid_d;
      exec_q  <= exec_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_exec     = exec_q;
  assign o_flags    = flags_q;
  assign o_skip_cnt = cnt_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: vector table, hand sequences and random
// stimulus against a spec-level model of the flag unit.
module tb_cond_flag_unit;

  logic        clk = 1'b0;
  bit          clk_en = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  cond;
  logic        we;
  logic [3:0]  flag;
  logic        stall;
  logic        clr;

  logic        o_valid, o_exec;
  logic [3:0]  o_flags;
  logic [15:0] o_cnt;
  logic        o_valid2, o_exec2;
  logic [3:0]  o_flags2;
  logic [1:0]  o_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 if (clk_en) clk = ~clk;

  cond_flag_unit dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_cond(cond),
    .i_flag_we(we), .i_flag(flag), .i_stall(stall),
    .i_cnt_clr(clr), .o_valid(o_valid), .o_exec(o_exec),
    .o_flags(o_flags), .o_skip_cnt(o_cnt)
  );

  cond_flag_unit #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_cond(cond),
    .i_flag_we(we), .i_flag(flag), .i_stall(stall),
    .i_cnt_clr(clr), .o_valid(o_valid2), .o_exec(o_exec2),
    .o_flags(o_flags2), .o_skip_cnt(o_cnt2)
  );

  // reference state
  logic [3:0]  m_flags;
  bit          m_valid, m_exec;
  int unsigned m_cnt, m_cnt2;

  function automatic bit ref_pass(logic [3:0] cd, logic [3:0] f);
    bit fn, fz, fc, fv;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    case (cd)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return fz || (fn != fv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_valid = 0;
    m_exec  = 0;
    m_cnt   = 0;
    m_cnt2  = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("valid", int'(o_valid), int'(m_valid));
    chk("exec", int'(o_exec), int'(m_exec));
    chk("flags", int'(o_flags), int'(m_flags));
    chk("cnt", int'(o_cnt), int'(m_cnt));
    chk("valid2", int'(o_valid2), int'(m_valid));
    chk("exec2", int'(o_exec2), int'(m_exec));
    chk("flags2", int'(o_flags2), int'(m_flags));
    chk("cnt2", int'(o_cnt2), int'(m_cnt2));
  endtask

  // apply one cycle of inputs, advance the model, sample after edge
  task automatic cycle(bit vl, logic [3:0] cd, bit w,
                       logic [3:0] f, bit st, bit cl);
    bit acc, p;
    valid = vl; cond = cd; we = w; flag = f;
    stall = st; clr = cl;
    acc = vl && !st;
    p   = ref_pass(cd, m_flags);
    if (cl) begin
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (acc && !p) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (!st) begin
      m_valid = vl;
      m_exec  = vl && p;
    end
    if (acc && w && p) m_flags = {f[3], f[2], !f[1], f[0]};
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_flags", int'(o_flags), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_exec", int'(o_exec), 0);
    chk("rst_cnt", int'(o_cnt), 0);
    chk("rst_cnt2", int'(o_cnt2), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit         vl;
    logic [3:0] cd;
    bit         w;
    logic [3:0] f;
    bit         cl;
    bit         e_valid;
    bit         e_exec;
    logic [3:0] e_flags;
    int         e_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // vl cd w f cl | valid exec flags cnt
    tbl[0]  = '{1, 4'hE, 1, 4'b0100, 0, 1, 1, 4'b0110, 0};
    tbl[1]  = '{1, 4'h0, 0, 4'b0000, 0, 1, 1, 4'b0110, 0};
    tbl[2]  = '{1, 4'h1, 0, 4'b0000, 0, 1, 0, 4'b0110, 1};
    tbl[3]  = '{1, 4'hE, 1, 4'b1010, 0, 1, 1, 4'b1000, 1};
    tbl[4]  = '{1, 4'h3, 0, 4'b0000, 0, 1, 1, 4'b1000, 1};
    tbl[5]  = '{1, 4'h8, 0, 4'b0000, 0, 1, 0, 4'b1000, 2};
    tbl[6]  = '{1, 4'hB, 0, 4'b0000, 0, 1, 1, 4'b1000, 2};
    tbl[7]  = '{1, 4'hA, 0, 4'b0000, 0, 1, 0, 4'b1000, 3};
    tbl[8]  = '{1, 4'hE, 1, 4'b0100, 0, 1, 1, 4'b0110, 3};
    tbl[9]  = '{1, 4'h1, 1, 4'b1010, 0, 1, 0, 4'b0110, 4};
    tbl[10] = '{1, 4'h0, 1, 4'b1010, 0, 1, 1, 4'b1000, 4};
    tbl[11] = '{0, 4'h0, 1, 4'b0000, 0, 0, 0, 4'b1000, 4};
    tbl[12] = '{1, 4'hF, 1, 4'b0000, 0, 1, 0, 4'b1000, 5};
    tbl[13] = '{0, 4'h0, 0, 4'b0000, 1, 0, 0, 4'b1000, 0};
    tbl[14] = '{1, 4'h4, 0, 4'b0000, 0, 1, 1, 4'b1000, 0};
    tbl[15] = '{1, 4'h5, 0, 4'b0000, 0, 1, 0, 4'b1000, 1};

    valid = 0; cond = 0; we = 0; flag = 0; stall = 0; clr = 0;
    rst = 1'b1;
    model_reset();
    #2;
    // clock not yet running
    chk("r0_flags", int'(o_flags), 0);
    chk("r0_valid", int'(o_valid), 0);
    chk("r0_exec", int'(o_exec), 0);
    chk("r0_cnt", int'(o_cnt), 0);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].vl, tbl[i].cd, tbl[i].w, tbl[i].f, 0, tbl[i].cl);
      chk($sformatf("v%0d_valid", i), int'(o_valid),
          int'(tbl[i].e_valid));
      chk($sformatf("v%0d_exec", i), int'(o_exec),
          int'(tbl[i].e_exec));
      chk($sformatf("v%0d_flags", i), int'(o_flags),
          int'(tbl[i].e_flags));
      chk($sformatf("v%0d_cnt", i), int'(o_cnt), tbl[i].e_cnt);
    end

    // stall: everything frozen, then exactly one decision
    cycle(1, 4'hE, 1, 4'b0000, 0, 0);
    chk("pre_flags", int'(o_flags), 4'b0010);
    for (int i = 0; i < 3; i++) begin
      cycle(i % 2 == 0, 4'(i * 5), 1, 4'(i + 4), 1, 0);
      chk("st_valid", int'(o_valid), 1);
      chk("st_exec", int'(o_exec), 1);
      chk("st_flags", int'(o_flags), 4'b0010);
      chk("st_cnt", int'(o_cnt), 1);
    end
    cycle(1, 4'h2, 0, 4'b0000, 0, 0);
    chk("rel_valid", int'(o_valid), 1);
    chk("rel_exec", int'(o_exec), 1);
    cycle(0, 4'h2, 0, 4'b0000, 0, 0);
    chk("rel_idle", int'(o_valid), 0);

    // saturation on the 2-bit counter instance
    async_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 4'hF, 0, 4'b0000, 0, 0);
      chk($sformatf("sat%0d", i), int'(o_cnt2), (i < 3) ? i + 1 : 3);
    end
    cycle(1, 4'hF, 0, 4'b0000, 0, 1);
    chk("clr_nv", int'(o_cnt2), 0);
    cycle(1, 4'hF, 0, 4'b0000, 1, 1);
    chk("clr_stall", int'(o_cnt2), 0);
    cycle(1, 4'hF, 0, 4'b0000, 0, 0);
    cycle(1, 4'hE, 1, 4'b1111, 0, 0);
    chk("pre_rst2", int'(o_cnt2), 1);
    async_reset();
    // first instruction after reset sees RESET_FLAGS
    cycle(1, 4'h1, 0, 4'b0000, 0, 0);
    chk("post_ne", int'(o_exec), 1);
    cycle(1, 4'h0, 0, 4'b0000, 0, 0);
    chk("post_eq", int'(o_exec), 0);
    chk_model();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 30) == 0);
      chk_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
